// File: rtl/mux4x1_rr.sv
// Four-channel round-robin merge into one registered, handshaked output word.
// Define MUX4X1_FIXED_PRIORITY_EN to replace round-robin with fixed priority a > b > c > d.
module mux4x1_rr #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic             valid_a,
    input  logic             valid_b,
    input  logic             valid_c,
    input  logic             valid_d,
    output logic             ready_a,
    output logic             ready_b,
    output logic             ready_c,
    output logic             ready_d,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       select,
    output logic             enable,
    input  logic             ack
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       last_grant_r;
    logic [1:0]       prio_base_s;
    logic [WIDTH-1:0] out_r;
    logic [1:0]       select_r;
    logic             enable_r;
    logic [3:0]       valid_s;
    logic [3:0]       ready_s;
    logic [2:0]       pick_s;
    logic [1:0]       winner_s;
    logic             any_valid_s;
    logic             load_s;
    logic             accept_s;
    logic [WIDTH-1:0] win_data_s;

    // Scan from base+1 upward with wrap; returns {found, index}. Iterating
    // from the lowest-priority offset lets the highest-priority hit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] base);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = base + i[1:0];
            if (v[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

`ifdef MUX4X1_FIXED_PRIORITY_EN
    assign prio_base_s = 2'b11;
`else
    assign prio_base_s = last_grant_r;
`endif

    // Arbitration and handshake decode
    always_comb begin
        valid_s     = {valid_d, valid_c, valid_b, valid_a};
        pick_s      = rr_pick(valid_s, prio_base_s);
        any_valid_s = pick_s[2];
        winner_s    = pick_s[1:0];
        load_s      = run & ~reset & ((state_r == EMPTY) | ack);
        accept_s    = load_s & any_valid_s;
        if (accept_s) begin
            ready_s = 4'b0001 << winner_s;
        end else begin
            ready_s = 4'b0000;
        end
        case (winner_s)
            2'd0:    win_data_s = in_a;
            2'd1:    win_data_s = in_b;
            2'd2:    win_data_s = in_c;
            2'd3:    win_data_s = in_d;
            default: win_data_s = in_a;
        endcase
    end

    // Next-state: fill on acceptance, drain on ack without a replacement
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            FULL: begin
                if (ack & ~accept_s) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // Output word register, FSM state and rotating pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= EMPTY;
            last_grant_r <= 2'b11;
            out_r        <= {WIDTH{1'b0}};
            select_r     <= 2'b00;
            enable_r     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            enable_r <= (state_next_s == FULL);
            if (accept_s) begin
                out_r        <= win_data_s;
                select_r     <= winner_s;
                last_grant_r <= winner_s;
            end else begin
                out_r        <= out_r;
                select_r     <= select_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign ready_a = ready_s[0];
    assign ready_b = ready_s[1];
    assign ready_c = ready_s[2];
    assign ready_d = ready_s[3];
    assign out     = out_r;
    assign select  = select_r;
    assign enable  = enable_r;

endmodule

// File: tb/tb_mux4x1_rr.sv
// Self-checking bench for mux4x1_rr: behavioural model compared every cycle plus directed literal checks.
module tb_mux4x1_rr;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         run;
    logic         ack;
    logic [W-1:0] in_v [4];
    logic [3:0]   valid_v;
    logic         ready_a, ready_b, ready_c, ready_d;
    logic [W-1:0] out;
    logic [1:0]   select;
    logic         enable;
    logic         started = 1'b0;

    int checks = 0;
    int errors = 0;

    mux4x1_rr #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .run(run),
        .in_a(in_v[0]), .in_b(in_v[1]), .in_c(in_v[2]), .in_d(in_v[3]),
        .valid_a(valid_v[0]), .valid_b(valid_v[1]), .valid_c(valid_v[2]), .valid_d(valid_v[3]),
        .ready_a(ready_a), .ready_b(ready_b), .ready_c(ready_c), .ready_d(ready_d),
        .out(out), .select(select), .enable(enable), .ack(ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one held word, and the channel most recently served.
    logic         m_full;
    logic [1:0]   m_last;
    logic [1:0]   m_sel;
    logic [W-1:0] m_out;

    function automatic logic [3:0] exp_ready();
        int start;
        if (reset) return 4'b0000;
        if (!(run && (!m_full || ack))) return 4'b0000;
`ifdef MUX4X1_FIXED_PRIORITY_EN
        start = 0;
`else
        start = (int'(m_last) + 1) % 4;
`endif
        for (int k = 0; k < 4; k++) begin
            int ch;
            ch = (start + k) % 4;
            if (valid_v[ch]) return 4'(1 << ch);
        end
        return 4'b0000;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_full <= 1'b0;
            m_last <= 2'b11;
            m_sel  <= 2'b00;
            m_out  <= '0;
        end else begin
            logic [3:0] r;
            int         g;
            r = exp_ready();
            g = 0;
            for (int j = 0; j < 4; j++) if (r[j]) g = j;
            if (r != 4'b0000) begin
                m_full <= 1'b1;
                m_out  <= in_v[g];
                m_sel  <= 2'(g);
                m_last <= 2'(g);
            end else if (m_full && ack) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("model_ready", 32'({ready_d, ready_c, ready_b, ready_a}), 32'(exp_ready()));
            check("model_enable", 32'(enable), 32'(m_full));
            check("model_select", 32'(select), 32'(m_sel));
            check("model_out", 32'(out), 32'(m_out));
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    function automatic logic [3:0] rdy();
        return {ready_d, ready_c, ready_b, ready_a};
    endfunction

    initial begin
        logic [1:0] es;
        logic [3:0] er;
        reset = 1'b1; run = 1'b1; ack = 1'b0; valid_v = 4'b0000;
        in_v[0] = 8'h11; in_v[1] = 8'hB1; in_v[2] = 8'hC2; in_v[3] = 8'hD3;
        nxt(); nxt();
        started = 1'b1;

        // First transfer after reset, then hold with ack low
        reset = 1'b0; valid_v = 4'b0001;
        mid(); check("t1_ready_a", 32'(rdy()), 32'h1); check("t1_en0", 32'(enable), 32'h0);
        nxt(); valid_v = 4'b0000;
        mid(); check("t1_out", 32'(out), 32'h11); check("t1_sel", 32'(select), 32'h0);
        check("t1_en", 32'(enable), 32'h1);
        repeat (3) begin
            nxt(); mid();
            check("t1_hold_out", 32'(out), 32'h11); check("t1_hold_sel", 32'(select), 32'h0);
            check("t1_hold_rdy", 32'(rdy()), 32'h0);
        end
        nxt(); ack = 1'b1;
        mid(); check("t1_deliver_en", 32'(enable), 32'h1);
        nxt(); mid(); check("t1_drained", 32'(enable), 32'h0);

        // All four valid, ack high: one word per cycle
        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0; in_v[0] = 8'hA0; valid_v = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            mid();
`ifdef MUX4X1_FIXED_PRIORITY_EN
            er = 4'b0001; es = 2'd0;
`else
            er = 4'(1 << (k % 4)); es = 2'((k + 3) % 4);
`endif
            check("t2_ready", 32'(rdy()), 32'(er));
            if (k >= 1) begin
                check("t2_sel", 32'(select), 32'(es));
                check("t2_out", 32'(out), 32'(in_v[es]));
            end
            nxt();
        end
        valid_v = 4'b0000;
        mid(); check("t2_last_sel", 32'(select), 32'h0); check("t2_last_out", 32'(out), 32'hA0);
        nxt(); mid(); check("t2_drained", 32'(enable), 32'h0);

`ifndef MUX4X1_FIXED_PRIORITY_EN
        // last_grant=1, a and c contend: c then a
        nxt(); valid_v = 4'b0010;
        mid(); check("t3_ready_b", 32'(rdy()), 32'h2);
        nxt(); valid_v = 4'b0101;
        mid(); check("t3_sel_b", 32'(select), 32'h1); check("t3_ready_c", 32'(rdy()), 32'h4);
        nxt(); mid(); check("t3_sel_c", 32'(select), 32'h2); check("t3_out_c", 32'(out), 32'hC2);
        check("t3_ready_a", 32'(rdy()), 32'h1);
        nxt(); valid_v = 4'b0000;
        mid(); check("t3_sel_a", 32'(select), 32'h0); check("t3_out_a", 32'(out), 32'hA0);
        nxt(); mid();

        // Reset while holding channel d
        nxt(); ack = 1'b0; valid_v = 4'b1000;
        mid(); check("t4_ready_d", 32'(rdy()), 32'h8);
        nxt(); valid_v = 4'b1001;
        mid(); check("t4_sel_d", 32'(select), 32'h3); check("t4_en", 32'(enable), 32'h1);
        nxt(); reset = 1'b1; ack = 1'b1;
        mid(); check("t4_rst_en", 32'(enable), 32'h0); check("t4_rst_rdy", 32'(rdy()), 32'h0);
        check("t4_rst_out", 32'(out), 32'h0);
        nxt(); reset = 1'b0;
        mid(); check("t4_restart_a", 32'(rdy()), 32'h1);
        nxt(); valid_v = 4'b0000;
        mid(); check("t4_sel_a", 32'(select), 32'h0);
        nxt(); mid();

        // run=0 while full: deliver, no reload, then resume
        nxt(); ack = 1'b0; valid_v = 4'b0010;
        mid(); check("t5_ready_b", 32'(rdy()), 32'h2);
        nxt(); valid_v = 4'b0110; run = 1'b0; ack = 1'b1;
        mid(); check("t5_en", 32'(enable), 32'h1); check("t5_sel", 32'(select), 32'h1);
        check("t5_norun_rdy", 32'(rdy()), 32'h0);
        nxt(); mid(); check("t5_drop", 32'(enable), 32'h0); check("t5_idle_rdy", 32'(rdy()), 32'h0);
        nxt(); run = 1'b1;
        mid(); check("t5_resume_c", 32'(rdy()), 32'h4);
        nxt(); valid_v = 4'b0000;
        mid(); check("t5_sel_c", 32'(select), 32'h2); check("t5_out_c", 32'(out), 32'hC2);
`endif

        nxt(); nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux4x1_rr.md
Name: mux4x1_rr

Overview:
- Collecting end of the 1-to-4 distribution path: merges four independent producer channels (a..d) into one registered stream.
- Each transfer carries its channel index on `select`, plus an `enable` strobe, so the stream drives a downstream 1x4 demux directly.
- Round-robin arbitration with a valid/ready handshake on every input and a one-word output register.
- Two-state FSM (EMPTY/FULL) with a rotating priority pointer.

Parameters:
- WIDTH, 1, data width of every input channel and of `out`.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  global gate; 0 blocks new acceptances, does not flush the held word
- in_a, in_b, in_c, in_d  input  WIDTH each  channel data
- valid_a, valid_b, valid_c, valid_d  input  1 each  channel has data
- ready_a, ready_b, ready_c, ready_d  output  1 each  channel word accepted this cycle when valid_x & ready_x
- out  output  WIDTH  held data word
- select  output  2  channel index of `out`: 0=a, 1=b, 2=c, 3=d
- enable  output  1  `out`/`select` hold a valid word
- ack  input  1  downstream consumes the held word this cycle when enable & ack

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-high on `reset`.
- Reset values: out=0, select=2'b00, enable=0, state=EMPTY, last_grant=2'b11 (so channel a has first priority).
- ready_a..d are 0 while reset is asserted.
- Load condition: `load = run & (state==EMPTY | ack)`.
- Arbitration (combinational):
  - Scan valid_x starting at index last_grant+1 (mod 4), wrapping; the first asserted channel wins.
  - ready_x = load & (winner==x) & valid_x. At most one ready is high per cycle.
  - If no valid_x is asserted, all ready are 0.
- EMPTY state:
  - On acceptance, at the next edge: out<=winner data, select<=winner index, enable<=1, last_grant<=winner, go to FULL.
  - Latency: valid in cycle N gives enable=1 in cycle N+1.
- FULL state:
  - out, select and enable stay stable until ack=1.
  - On ack with a new acceptance: reload in the same edge, stay FULL. Gives back-to-back throughput of 1 word/cycle.
  - On ack with no acceptance (no valid, or run=0): enable<=0, go to EMPTY. `out`/`select` keep their last value.
- run=0 while FULL: the held word is still delivered on ack; no reload follows.
- Fairness: a channel that is continuously valid waits at most 3 grants of other channels.
- Simultaneous valids: resolved purely by the rotating pointer. Example: last_grant=1 with valid_a and valid_c both high grants c.
- Input holding: a channel that drops valid before being accepted is simply skipped. No input is latched except on valid&ready.
- Reset mid-transfer: the held word is discarded and all state returns to reset values immediately (asynchronous). No ready pulse completes in the reset cycle.
- Width: `out` is exactly WIDTH bits; no truncation or extension.

Optional Feature:
- Macro: MUX4X1_FIXED_PRIORITY_EN.
- Defined: arbitration is fixed priority a > b > c > d and last_grant is ignored (it may be left unused). All handshake and FSM behaviour is unchanged.
- Undefined: round-robin arbitration as above.

Test Plan:
- Reset with a=8'h11 valid, then release reset -> ready_a=1 in the first cycle; next cycle out=8'h11, select=0, enable=1. Hold ack=0 for 3 cycles -> out and select unchanged, all ready=0.
- All four valid (a=8'hA0, b=8'hB1, c=8'hC2, d=8'hD3), ack=1 constant -> select sequence 0,1,2,3,0, one word per cycle, data matches each channel.
- last_grant=1, only valid_a and valid_c high -> c granted (select=2), then a (select=0).
- Assert reset for 1 cycle while FULL with select=3 -> enable=0 and ready all 0 immediately; after release, priority restarts at a.
- run=0 while FULL, ack=1 -> held word delivered, enable drops next cycle, no ready pulses. run=1 again -> normal acceptance resumes.
- With MUX4X1_FIXED_PRIORITY_EN defined, all four valid, ack=1 -> select stays 0 every cycle; b, c, d are never granted.
